// File: rtl/mem_port2_arbiter_if.sv
// Port-2 bus bundle: CPU D-cache side, DMA BR/BG handshake, memory side and grant statistics.
// slave is the arbiter; master is the requesters plus the memory.
interface mem_port2_arbiter_if #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned BLOCK_SIZE = 64
);
  logic                  cpu_req;
  logic                  cpu_write;
  logic [WORD_SIZE-1:0]  cpu_addr;
  logic [BLOCK_SIZE-1:0] cpu_wdata;
  logic [BLOCK_SIZE-1:0] cpu_rdata;
  logic                  cpu_done;
  logic                  cpu_stall;
  logic                  dma_br;
  logic                  dma_bg;
  logic                  dma_req;
  logic                  dma_write;
  logic [WORD_SIZE-1:0]  dma_addr;
  logic [BLOCK_SIZE-1:0] dma_wdata;
  logic                  dma_done;
  logic                  mem_read;
  logic                  mem_write;
  logic [WORD_SIZE-1:0]  mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic [BLOCK_SIZE-1:0] mem_rdata;
  logic                  mem_ready;
  logic [15:0]           grant_count;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dma_br, dma_req, dma_write, dma_addr, dma_wdata,
    output dma_bg, dma_done,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output grant_count
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dma_br, dma_req, dma_write, dma_addr, dma_wdata,
    input  dma_bg, dma_done,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  grant_count
  );
endinterface

// File: rtl/mem_port2_arbiter.sv
// Arbiter for memory port 2: CPU D-cache vs DMA (BR/BG), no mid-access grant changes,
// bounded DMA tenure while a CPU access is stalled.
module mem_port2_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned BLOCK_SIZE   = 64,
  parameter int unsigned MAX_DMA_HOLD = 32
) (
  input logic                clk,
  input logic                reset,
  mem_port2_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StCpuAcc,
    StDmaOwn,
    StDmaAcc,
    StCpuSlot,
    StCpuSlotAcc
  } state_e;

  state_e                state_q;
  logic                  dma_bg_q;
  logic                  cpu_done_q;
  logic                  dma_done_q;
  logic [BLOCK_SIZE-1:0] cpu_rdata_q;
  logic [15:0]           grant_count_q;
  logic [31:0]           hold_q;
  logic                  hold_expired;
  logic                  cpu_acc;
  logic                  rd_d;
  logic                  wr_d;
  logic [WORD_SIZE-1:0]  addr_d;
  logic [BLOCK_SIZE-1:0] wdata_d;

  assign hold_expired = (MAX_DMA_HOLD != 0) && (hold_q >= MAX_DMA_HOLD);
  assign cpu_acc      = (state_q == StCpuAcc) || (state_q == StCpuSlotAcc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      dma_bg_q      <= 1'b0;
      cpu_done_q    <= 1'b0;
      dma_done_q    <= 1'b0;
      cpu_rdata_q   <= '0;
      grant_count_q <= '0;
      hold_q        <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      // Hold counter only measures how long the CPU has been kept waiting by the DMA.
      if ((state_q == StDmaOwn || state_q == StDmaAcc) && bus.cpu_req && (hold_q != '1)) begin
        hold_q <= hold_q + 32'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            state_q <= StCpuAcc;
          end else if (bus.dma_br) begin
            state_q       <= StDmaOwn;
            dma_bg_q      <= 1'b1;
            grant_count_q <= grant_count_q + 16'd1;
            hold_q        <= '0;
          end
        end
        StCpuAcc, StCpuSlotAcc: begin
          if (bus.mem_ready) begin
            if (!bus.cpu_write) cpu_rdata_q <= bus.mem_rdata;
            cpu_done_q <= 1'b1;
            if (bus.dma_br) begin
              state_q       <= StDmaOwn;
              dma_bg_q      <= 1'b1;
              grant_count_q <= grant_count_q + 16'd1;
              hold_q        <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDmaOwn: begin
          // Preemption wins over a new DMA request so a busy DMA cannot starve the CPU.
          if (hold_expired && bus.cpu_req) begin
            state_q  <= StCpuSlot;
            dma_bg_q <= 1'b0;
          end else if (bus.dma_req) begin
            state_q <= StDmaAcc;
          end else if (!bus.dma_br) begin
            state_q  <= StIdle;
            dma_bg_q <= 1'b0;
          end
        end
        StDmaAcc: begin
          if (bus.mem_ready) begin
            state_q    <= StDmaOwn;
            dma_done_q <= 1'b1;
          end
        end
        StCpuSlot: state_q <= StCpuSlotAcc;
        default:   state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (cpu_acc) begin
      rd_d    = ~bus.cpu_write;
      wr_d    = bus.cpu_write;
      addr_d  = bus.cpu_addr;
      wdata_d = bus.cpu_wdata;
    end else if (state_q == StDmaAcc) begin
      rd_d    = ~bus.dma_write;
      wr_d    = bus.dma_write;
      addr_d  = bus.dma_addr;
      wdata_d = bus.dma_wdata;
    end
  end

  assign bus.mem_read    = rd_d;
  assign bus.mem_write   = wr_d;
  assign bus.mem_addr    = addr_d;
  assign bus.mem_wdata   = wdata_d;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_done    = cpu_done_q;
  assign bus.dma_done    = dma_done_q;
  assign bus.dma_bg      = dma_bg_q;
  assign bus.grant_count = grant_count_q;
  assign bus.cpu_stall   = bus.cpu_req & ~reset & ~cpu_acc;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Bench for mem_port2_arbiter: directed scenarios plus randomized traffic checked against
// transaction-level rules (ownership, done pulses, grant counting, tenure bound).
module tb_mem_port2_arbiter;
  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned MAX_HOLD   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port2_arbiter_if #(.WORD_SIZE(WORD_SIZE), .BLOCK_SIZE(BLOCK_SIZE)) bus ();

  mem_port2_arbiter #(
    .WORD_SIZE   (WORD_SIZE),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .MAX_DMA_HOLD(MAX_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_br    = 1'b0;
    bus.dma_req   = 1'b0;
    bus.dma_write = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.dma_br    = 1'b1;
    bus.mem_ready = 1'b1;
    cyc();
    checks++;
    if (bus.dma_bg !== 1'b0) begin
      failures++; $display("FAIL reset_bg got=%0b exp=0", bus.dma_bg);
    end
    checks++;
    if (bus.grant_count !== 16'd0) begin
      failures++; $display("FAIL reset_gc got=%0d exp=0", bus.grant_count);
    end
    checks++;
    if (bus.cpu_rdata !== 64'd0) begin
      failures++; $display("FAIL reset_rdata got=%0h exp=0", bus.cpu_rdata);
    end
    checks++;
    if ({bus.cpu_done, bus.dma_done} !== 2'b00) begin
      failures++; $display("FAIL reset_done got=%b exp=00", {bus.cpu_done, bus.dma_done});
    end
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== 18'd0) begin
      failures++; $display("FAIL reset_mem got=%0h exp=0", {bus.mem_read, bus.mem_write, bus.mem_addr});
    end
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%0b exp=0", bus.cpu_stall);
    end
  endtask

  task automatic test_idle_grant();
    do_reset();
    cyc();
    bus.dma_br = 1'b1;
    cyc();
    checks++;
    if (bus.dma_bg !== 1'b1 || bus.grant_count !== 16'd1) begin
      failures++; $display("FAIL idle_grant got bg=%0b gc=%0d exp bg=1 gc=1", bus.dma_bg, bus.grant_count);
    end
    cyc();
    checks++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      failures++; $display("FAIL grant_no_req_mem got=%b exp=00", {bus.mem_read, bus.mem_write});
    end
    bus.dma_req   = 1'b1;
    bus.dma_write = 1'b1;
    bus.dma_addr  = 16'h0040;
    bus.dma_wdata = 64'hA5A5_0000_FFFF_5A5A;
    cyc();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0040 || bus.mem_wdata !== 64'hA5A5_0000_FFFF_5A5A) begin
      failures++; $display("FAIL dma_write_mem got w=%0b a=%0h d=%0h exp w=1 a=40 d=a5a50000ffff5a5a",
                           bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    bus.dma_req   = 1'b0;
    checks++;
    if (bus.dma_done !== 1'b1) begin
      failures++; $display("FAIL dma_done_pulse got=%0b exp=1", bus.dma_done);
    end
    bus.dma_br = 1'b0;
    cyc();
    checks++;
    if (bus.dma_bg !== 1'b0 || bus.dma_done !== 1'b0) begin
      failures++; $display("FAIL dma_release got bg=%0b done=%0b exp 0 0", bus.dma_bg, bus.dma_done);
    end
    // Ungranted dma_req and stray mem_ready must both be ignored.
    bus.dma_req = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.dma_done, bus.dma_bg} !== 4'b0000) begin
      failures++; $display("FAIL ungranted_req got=%b exp=0000",
                           {bus.mem_read, bus.mem_write, bus.dma_done, bus.dma_bg});
    end
    bus.dma_req   = 1'b0;
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.cpu_done, bus.dma_done} !== 2'b00) begin
      failures++; $display("FAIL stray_ready got=%b exp=00", {bus.cpu_done, bus.dma_done});
    end
  endtask

  task automatic test_grant_deferred();
    do_reset();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0010;
    cyc();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.cpu_stall !== 1'b0) begin
      failures++; $display("FAIL cpu_load_mem got rd=%0b a=%0h st=%0b exp rd=1 a=10 st=0",
                           bus.mem_read, bus.mem_addr, bus.cpu_stall);
    end
    bus.dma_br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (bus.dma_bg !== 1'b0) begin
        failures++; $display("FAIL deferred_bg cycle=%0d got=%0b exp=0", i, bus.dma_bg);
      end
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h1122_3344_5566_7788;
    cyc();
    bus.mem_ready = 1'b0;
    bus.cpu_req   = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 64'h1122_3344_5566_7788) begin
      failures++; $display("FAIL deferred_load got done=%0b rdata=%0h exp done=1 rdata=1122334455667788",
                           bus.cpu_done, bus.cpu_rdata);
    end
    checks++;
    if (bus.dma_bg !== 1'b1 || bus.grant_count !== 16'd1) begin
      failures++; $display("FAIL deferred_grant got bg=%0b gc=%0d exp bg=1 gc=1", bus.dma_bg, bus.grant_count);
    end
    bus.dma_br = 1'b0;
    cyc();
  endtask

  task automatic test_tie();
    do_reset();
    bus.cpu_req   = 1'b1;
    bus.cpu_write = 1'b1;
    bus.cpu_addr  = 16'h0022;
    bus.cpu_wdata = 64'hDEAD_BEEF_0123_4567;
    bus.dma_br    = 1'b1;
    cyc();
    checks++;
    if (bus.dma_bg !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0022) begin
      failures++; $display("FAIL tie_cpu_first got bg=%0b w=%0b a=%0h exp bg=0 w=1 a=22",
                           bus.dma_bg, bus.mem_write, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    bus.mem_ready = 1'b0;
    bus.cpu_req   = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.dma_bg !== 1'b1 || bus.cpu_rdata !== 64'd0) begin
      failures++; $display("FAIL tie_after got done=%0b bg=%0b rdata=%0h exp done=1 bg=1 rdata=0",
                           bus.cpu_done, bus.dma_bg, bus.cpu_rdata);
    end
    bus.dma_br = 1'b0;
    cyc();
  endtask

  task automatic test_preempt();
    int n;
    do_reset();
    bus.dma_br = 1'b1;
    cyc();
    bus.cpu_req   = 1'b1;
    bus.cpu_write = 1'b1;
    bus.cpu_addr  = 16'h0017;
    bus.cpu_wdata = 64'h0BAD_CAFE_1234_9876;
    n = 0;
    for (int i = 0; i < 40 && bus.dma_bg; i++) begin
      cyc();
      if (bus.dma_bg) n++;
    end
    checks++;
    if (n != MAX_HOLD) begin
      failures++; $display("FAIL preempt_hold got=%0d exp=%0d", n, MAX_HOLD);
    end
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.mem_write !== 1'b0) begin
      failures++; $display("FAIL preempt_slot got st=%0b w=%0b exp st=1 w=0", bus.cpu_stall, bus.mem_write);
    end
    cyc();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0017 || bus.mem_wdata !== 64'h0BAD_CAFE_1234_9876
        || bus.dma_bg !== 1'b0) begin
      failures++; $display("FAIL preempt_store got w=%0b a=%0h d=%0h bg=%0b exp w=1 a=17 bg=0",
                           bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.dma_bg);
    end
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    bus.cpu_req   = 1'b0;
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.dma_bg !== 1'b1 || bus.grant_count !== 16'd2) begin
      failures++; $display("FAIL preempt_regrant got done=%0b bg=%0b gc=%0d exp 1 1 2",
                           bus.cpu_done, bus.dma_bg, bus.grant_count);
    end
    cyc();
    checks++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      failures++; $display("FAIL preempt_single got=%b exp=00", {bus.mem_read, bus.mem_write});
    end
    bus.dma_br = 1'b0;
    cyc();
  endtask

  task automatic test_release();
    do_reset();
    bus.dma_br = 1'b1;
    cyc();
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0033;
    cyc();
    bus.dma_br = 1'b0;
    cyc();
    checks++;
    if (bus.dma_bg !== 1'b1 || bus.mem_read !== 1'b1) begin
      failures++; $display("FAIL release_mid got bg=%0b rd=%0b exp 1 1", bus.dma_bg, bus.mem_read);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h5555_AAAA_5555_AAAA;
    cyc();
    bus.mem_ready = 1'b0;
    bus.dma_req   = 1'b0;
    checks++;
    if (bus.dma_done !== 1'b1 || bus.dma_bg !== 1'b1) begin
      failures++; $display("FAIL release_done got done=%0b bg=%0b exp 1 1", bus.dma_done, bus.dma_bg);
    end
    cyc();
    checks++;
    if (bus.dma_bg !== 1'b0 || bus.dma_done !== 1'b0) begin
      failures++; $display("FAIL release_bg got bg=%0b done=%0b exp 0 0", bus.dma_bg, bus.dma_done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.dma_br = 1'b1;
    cyc();
    bus.dma_br = 1'b0;
    cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0050;
    cyc();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.grant_count !== 16'd1) begin
      failures++; $display("FAIL pre_reset got rd=%0b gc=%0d exp 1 1", bus.mem_read, bus.grant_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_read, bus.cpu_stall, bus.dma_bg} !== 3'b000 || bus.grant_count !== 16'd0) begin
      failures++; $display("FAIL reset_mid got rd/st/bg=%b gc=%0d exp 000 0",
                           {bus.mem_read, bus.cpu_stall, bus.dma_bg}, bus.grant_count);
    end
    bus.mem_ready = 1'b1;
    cyc();
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.cpu_req   = 1'b0;
    cyc();
    checks++;
    if (bus.cpu_done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_done got=%0b exp=0", bus.cpu_done);
    end
  endtask

  task automatic test_random(input int n);
    int          exp_gc;
    int          tenure;
    int          wait_cnt;
    int          r;
    logic [63:0] exp_rdata;
    logic        prev_bg, prev_br, prev_cpu_act, prev_dma_act, prev_ready, prev_cpu_req, prev_idle;
    logic        act, cpu_act, dma_act;
    do_reset();
    exp_gc = 0; tenure = 0; wait_cnt = 0; exp_rdata = '0;
    prev_bg = 1'b0; prev_br = 1'b0; prev_cpu_act = 1'b0; prev_dma_act = 1'b0;
    prev_ready = 1'b0; prev_cpu_req = 1'b0; prev_idle = 1'b1;
    for (int i = 0; i < n; i++) begin
      // Registered outputs follow from what happened in the previous cycle.
      checks++;
      if (bus.cpu_done !== (prev_cpu_act && prev_ready)) begin
        failures++; $display("FAIL rnd_cpu_done cyc=%0d got=%0b exp=%0b", i, bus.cpu_done,
                             prev_cpu_act && prev_ready);
      end
      checks++;
      if (bus.dma_done !== (prev_dma_act && prev_ready)) begin
        failures++; $display("FAIL rnd_dma_done cyc=%0d got=%0b exp=%0b", i, bus.dma_done,
                             prev_dma_act && prev_ready);
      end
      if (bus.dma_bg && !prev_bg) begin
        exp_gc++;
        tenure = 0;
        checks++;
        if (!prev_br || (prev_cpu_act && !prev_ready)) begin
          failures++; $display("FAIL rnd_bad_grant cyc=%0d br=%0b cpu_busy=%0b exp br=1 cpu_busy=0",
                               i, prev_br, prev_cpu_act && !prev_ready);
        end
      end
      if (!bus.dma_bg && prev_bg && prev_br) begin
        checks++;
        if (tenure < int'(MAX_HOLD) + 1) begin
          failures++; $display("FAIL rnd_early_preempt cyc=%0d got=%0d exp>=%0d", i, tenure, MAX_HOLD + 1);
        end
      end
      checks++;
      if (bus.grant_count !== 16'(exp_gc)) begin
        failures++; $display("FAIL rnd_gc cyc=%0d got=%0d exp=%0d", i, bus.grant_count, 16'(exp_gc));
      end
      checks++;
      if (bus.cpu_rdata !== exp_rdata) begin
        failures++; $display("FAIL rnd_rdata cyc=%0d got=%0h exp=%0h", i, bus.cpu_rdata, exp_rdata);
      end
      // Requesters obey the protocol: hold requests until done, keep BR high unless granted.
      if (bus.cpu_done) begin
        bus.cpu_req = 1'b0;
      end else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_write = 1'($urandom);
        bus.cpu_addr  = 16'($urandom);
        bus.cpu_wdata = {$urandom, $urandom};
      end
      if (bus.dma_done) bus.dma_req = 1'b0;
      if (!bus.dma_br) begin
        if ($urandom_range(0, 7) == 0) bus.dma_br = 1'b1;
      end else if (bus.dma_bg && !bus.dma_req) begin
        r = int'($urandom_range(0, 7));
        if (r == 0) begin
          bus.dma_br = 1'b0;
        end else if (r <= 3) begin
          bus.dma_req   = 1'b1;
          bus.dma_write = 1'($urandom);
          bus.dma_addr  = 16'($urandom);
          bus.dma_wdata = {$urandom, $urandom};
        end
      end
      #1;
      act     = bus.mem_read || bus.mem_write;
      cpu_act = act && !bus.dma_bg;
      dma_act = act && bus.dma_bg;
      checks++;
      if (bus.mem_read && bus.mem_write) begin
        failures++; $display("FAIL rnd_rd_and_wr cyc=%0d got=11 exp=not both", i);
      end
      checks++;
      if (dma_act) begin
        if (bus.mem_write !== bus.dma_write || bus.mem_addr !== bus.dma_addr
            || bus.mem_wdata !== bus.dma_wdata || !bus.dma_req) begin
          failures++; $display("FAIL rnd_dma_mem cyc=%0d got a=%0h w=%0b exp a=%0h w=%0b", i,
                               bus.mem_addr, bus.mem_write, bus.dma_addr, bus.dma_write);
        end
      end else if (cpu_act) begin
        if (bus.mem_write !== bus.cpu_write || bus.mem_addr !== bus.cpu_addr
            || bus.mem_wdata !== bus.cpu_wdata || !bus.cpu_req) begin
          failures++; $display("FAIL rnd_cpu_mem cyc=%0d got a=%0h w=%0b exp a=%0h w=%0b", i,
                               bus.mem_addr, bus.mem_write, bus.cpu_addr, bus.cpu_write);
        end
      end else if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
        failures++; $display("FAIL rnd_idle_mem cyc=%0d got a=%0h d=%0h exp 0 0", i,
                             bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if (bus.cpu_stall !== (bus.cpu_req && !cpu_act)) begin
        failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, bus.cpu_stall,
                             bus.cpu_req && !cpu_act);
      end
      if (prev_idle && prev_cpu_req) begin
        checks++;
        if (!cpu_act) begin
          failures++; $display("FAIL rnd_cpu_priority cyc=%0d got=0 exp=1", i);
        end
      end
      if (bus.dma_bg && bus.cpu_req) begin
        tenure++;
        checks++;
        if (tenure == int'(MAX_HOLD) + 6) begin
          failures++; $display("FAIL rnd_tenure cyc=%0d got=%0d exp<=%0d", i, tenure, MAX_HOLD + 5);
        end
      end
      // Memory responder: 1..4 cycle accesses, occasional stray ready when idle.
      if (act) begin
        if (!(prev_cpu_act || prev_dma_act) || prev_ready) wait_cnt = int'($urandom_range(0, 3));
        bus.mem_ready = (wait_cnt == 0);
        if (wait_cnt != 0) wait_cnt--;
      end else begin
        bus.mem_ready = ($urandom_range(0, 15) == 0);
      end
      bus.mem_rdata = {$urandom, $urandom};
      if (cpu_act && bus.mem_ready && !bus.cpu_write) exp_rdata = bus.mem_rdata;
      prev_bg      = bus.dma_bg;
      prev_br      = bus.dma_br;
      prev_cpu_act = cpu_act;
      prev_dma_act = dma_act;
      prev_ready   = bus.mem_ready;
      prev_cpu_req = bus.cpu_req;
      prev_idle    = !bus.dma_bg && !act;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_idle_grant();
    test_grant_deferred();
    test_tie();
    test_preempt();
    test_release();
    test_reset_mid();
    test_random(4000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port2_arbiter.md
Name: mem_port2_arbiter

Overview:
- Shares memory port 2 (the 64-bit data port) between two requesters: the CPU data cache and the DMA controller.
- Implements the BR/BG bus-request/bus-grant handshake toward the DMA controller.
- Never grants the bus in the middle of an in-flight access.
- Bounds DMA bus tenure so that a stalled CPU load/store gets a guaranteed slot.

Parameters:
WORD_SIZE, 16, address width
BLOCK_SIZE, 64, data width of port 2
MAX_DMA_HOLD, 32, grant cycles before a forced CPU slot when cpu_req is pending; 0 disables preemption

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  D-cache access request, held until cpu_done
cpu_write  input  1  1=store, 0=load; valid with cpu_req
cpu_addr  input  WORD_SIZE  D-cache address
cpu_wdata  input  BLOCK_SIZE  D-cache store data
cpu_rdata  output  BLOCK_SIZE  registered load data
cpu_done  output  1  one-cycle pulse: CPU access complete
cpu_stall  output  1  cpu_req pending and bus not owned by CPU
dma_br  input  1  DMA bus request
dma_bg  output  1  DMA bus grant
dma_req  input  1  DMA access request; only honoured while dma_bg=1
dma_write  input  1  1=write, 0=read
dma_addr  input  WORD_SIZE  DMA address
dma_wdata  input  BLOCK_SIZE  DMA write data
dma_done  output  1  one-cycle pulse: DMA access complete
mem_read  output  1  to memory
mem_write  output  1  to memory
mem_addr  output  WORD_SIZE  to memory
mem_wdata  output  BLOCK_SIZE  to memory
mem_rdata  input  BLOCK_SIZE  from memory, valid with mem_ready
mem_ready  input  1  one-cycle pulse: current access done
grant_count  output  16  number of dma_bg rising edges, wraps at 65535->0

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset (async, active-high) forces IDLE.
  - All outputs are 0 at reset, including grant_count and cpu_rdata.
  - mem_read and mem_write drop immediately, even mid-access; the in-flight access is abandoned and no done pulse is issued.
- States: IDLE, CPU_ACC, DMA_OWN, DMA_ACC, CPU_SLOT, CPU_SLOT_ACC.
- IDLE:
  - cpu_req=1 -> CPU_ACC. CPU has priority when cpu_req and dma_br are both high.
  - else dma_br=1 -> DMA_OWN; dma_bg rises at this edge (one-cycle grant latency); grant_count increments.
- CPU_ACC:
  - mem_* driven combinationally from cpu_* while in this state.
  - On mem_ready: capture mem_rdata into cpu_rdata (loads only; stores leave cpu_rdata unchanged) and pulse cpu_done for the next cycle.
  - Next state: DMA_OWN if dma_br (grant), else IDLE.
  - The CPU must drop cpu_req in the cpu_done cycle to avoid a repeat access.
- DMA_OWN (dma_bg=1):
  - dma_req=1 -> DMA_ACC.
  - dma_br=0 -> IDLE; dma_bg falls at this edge.
  - Preemption check: if the hold counter >= MAX_DMA_HOLD (and MAX_DMA_HOLD != 0) and cpu_req=1 -> CPU_SLOT; dma_bg falls.
  - Hold counter counts every cycle in DMA_OWN/DMA_ACC while cpu_req=1; it clears on entering DMA_OWN from IDLE, CPU_ACC or CPU_SLOT_ACC.
- DMA_ACC:
  - mem_* driven from dma_*.
  - On mem_ready: pulse dma_done next cycle, return to DMA_OWN.
  - Preemption and BR release are never taken here. dma_br falling mid-access is ignored until completion.
- CPU_SLOT:
  - dma_bg=0; the DMA must pause and keep dma_br high.
  - Go to CPU_SLOT_ACC next cycle and perform exactly one CPU access.
  - On completion: DMA_OWN if dma_br (dma_bg re-rises, grant_count increments), else IDLE.
- Outputs:
  - mem_* are all zero outside CPU_ACC, DMA_ACC and CPU_SLOT_ACC.
  - cpu_stall = cpu_req & (state not in {CPU_ACC, CPU_SLOT_ACC}).
- Protocol violations:
  - dma_req while dma_bg=0 is ignored: no memory access, no dma_done.
  - mem_ready outside an access state is ignored.

Test Plan:
- Idle grant: reset, then dma_br=1 at cycle 2 -> dma_bg=1 at the edge ending cycle 2; grant_count=1; mem_* stay 0 until dma_req.
- Grant deferred: cpu_req load at addr 0x0010, dma_br rises 1 cycle later, mem_ready after 4 cycles -> dma_bg stays 0 throughout the access; cpu_done pulses with cpu_rdata=mem_rdata (e.g. 0x1122334455667788); dma_bg=1 the same edge.
- Tie: cpu_req and dma_br rise together in IDLE -> CPU access first; dma_bg only after cpu_done.
- Preemption: MAX_DMA_HOLD=8, DMA owns bus, cpu_req store addr 0x0017 -> dma_bg falls after 8 stalled cycles (after any in-flight DMA access completes); exactly one CPU store (mem_write=1, mem_addr=0x0017); dma_bg re-rises; grant_count=2.
- Release: dma_br falls during DMA_ACC -> access completes, dma_done pulses, then dma_bg falls next cycle.
- Reset mid-access: assert reset during CPU_ACC with mem_read=1 -> mem_read and cpu_stall drop immediately; no cpu_done; grant_count=0.
